// File: rtl/spi_mem_pkg.sv
// Shared definitions for the SPI memory burst controller: opcodes, FSM states,
// SPI mode-0 clock polarity and a counter-width helper.
package spi_mem_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  // Mode 0: SCK idles low, MOSI changes while SCK is low, MISO sampled at the end of the high phase
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SCK_IDLE = SPI_CPOL;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA,
    S_HOLD,
    S_GAP
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// SPI mode-0 bit engine: shifts one byte MSB first, generates SCK and samples MISO.
// A load on the last cycle of a byte chains the next byte with no idle cycle.
module spi_bit_engine
  import spi_mem_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_miso,
  output logic       o_sck,
  output logic       o_mosi,
  output logic       o_byte_last,
  output logic [7:0] o_rx_byte
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [7:0]       r_shift;
  logic [2:0]       r_bit_cnt;
  logic [DIV_W-1:0] r_div_cnt;
  logic             r_phase;
  logic             r_active;
  logic             r_sck;

  logic w_div_end;
  logic w_bit_end;

  assign w_div_end   = (r_div_cnt == DIV_LAST);
  assign w_bit_end   = r_active & r_phase & w_div_end;
  assign o_byte_last = w_bit_end & (r_bit_cnt == 3'd7);
  assign o_rx_byte   = {r_shift[6:0], i_miso};
  assign o_sck       = r_sck;
  assign o_mosi      = r_active & r_shift[7];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift   <= 8'h00;
      r_bit_cnt <= 3'd0;
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_active  <= 1'b0;
      r_sck     <= SCK_IDLE;
    end else if (i_load) begin
      r_shift   <= i_data;
      r_bit_cnt <= 3'd0;
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
      r_active  <= 1'b1;
      r_sck     <= SCK_IDLE;
    end else if (r_active) begin
      if (w_div_end) begin
        r_div_cnt <= '0;
        if (!r_phase) begin
          r_phase <= 1'b1;
          r_sck   <= ~SCK_IDLE;
        end else begin
          // Sample on the last high cycle, then drop SCK for the next bit
          r_phase   <= 1'b0;
          r_sck     <= SCK_IDLE;
          r_shift   <= {r_shift[6:0], i_miso};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_active <= 1'b0;
        end
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/spi_mem_burst_ctrl.sv
// SPI mode-0 master issuing READ/WRITE bursts of 1..MAX_BURST bytes to an SPI SRAM/FRAM,
// with valid/ready byte streaming on the write side and a one-cycle rvalid pulse on reads.
module spi_mem_burst_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_BYTES = 1,
  parameter int MAX_BURST  = 4,
  parameter int CLK_DIV    = 2,
  parameter int LEN_W      = cnt_width(MAX_BURST)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_wr,
  input  logic [8*ADDR_BYTES-1:0] i_addr,
  input  logic [LEN_W-1:0]        i_len,
  input  logic [7:0]              i_wdata,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [7:0]              o_rdata,
  output logic                    o_rvalid,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_spi_cs_n,
  output logic                    o_spi_sck,
  output logic                    o_spi_mosi,
  input  logic                    i_spi_miso
);

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [1:0]       ADDR_LAST = 2'(ADDR_BYTES - 1);

  state_t           r_state;
  logic             r_wr;
  logic [AW-1:0]    r_addr;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_byte_cnt;
  logic [1:0]       r_addr_cnt;
  logic             r_stall;
  logic [DIV_W-1:0] r_cnt;
  logic             r_cs_n;
  logic             r_busy;
  logic             r_done;
  logic             r_rvalid;
  logic [7:0]       r_rdata;

  logic       w_load;
  logic [7:0] w_load_data;
  logic       w_byte_last;
  logic [7:0] w_rx_byte;
  logic       w_last_addr;
  logic       w_last_data;
  logic       w_data_next;
  logic       w_need_byte;

  spi_bit_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_engine (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_load),
    .i_data      (w_load_data),
    .i_miso      (i_spi_miso),
    .o_sck       (o_spi_sck),
    .o_mosi      (o_spi_mosi),
    .o_byte_last (w_byte_last),
    .o_rx_byte   (w_rx_byte)
  );

  assign w_last_addr = (r_addr_cnt == ADDR_LAST);
  assign w_last_data = (r_byte_cnt == r_len);
  // A data byte must start next: after the final address byte or a non-final data byte
  assign w_data_next = w_byte_last &
                       (((r_state == S_ADDR) & w_last_addr) | ((r_state == S_DATA) & ~w_last_data));
  assign w_need_byte = w_data_next | r_stall;
  assign o_wready    = r_wr & w_need_byte;

  always_comb begin
    w_load      = 1'b0;
    w_load_data = 8'h00;
    case (r_state)
      S_IDLE: begin
        w_load      = i_start;
        w_load_data = i_wr ? OP_WRITE : OP_READ;
      end
      S_CMD, S_ADDR: begin
        if (w_byte_last && !((r_state == S_ADDR) && w_last_addr)) begin
          w_load      = 1'b1;
          w_load_data = r_addr[AW-1 -: 8];
        end
      end
      default: ;
    endcase
    if (w_need_byte) begin
      w_load      = !r_wr || i_wvalid;
      w_load_data = r_wr ? i_wdata : 8'h00;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_byte_cnt <= '0;
      r_addr_cnt <= 2'd0;
      r_stall    <= 1'b0;
      r_cnt      <= '0;
      r_cs_n     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 8'h00;
    end else begin
      r_done   <= 1'b0;
      r_rvalid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_wr    <= i_wr;
            r_addr  <= i_addr;
            r_len   <= i_len;
            r_cs_n  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_CMD;
          end
        end
        S_CMD: begin
          if (w_byte_last) begin
            r_addr     <= r_addr << 8;
            r_addr_cnt <= 2'd0;
            r_state    <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (w_byte_last) begin
            if (!w_last_addr) begin
              r_addr     <= r_addr << 8;
              r_addr_cnt <= r_addr_cnt + 2'd1;
            end else begin
              r_byte_cnt <= '0;
              r_stall    <= r_wr & ~i_wvalid;
              r_state    <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (r_stall && i_wvalid) r_stall <= 1'b0;
          if (w_byte_last) begin
            if (!r_wr) begin
              r_rdata  <= w_rx_byte;
              r_rvalid <= 1'b1;
            end
            if (w_last_data) begin
              r_cnt   <= '0;
              r_state <= S_HOLD;
            end else begin
              r_byte_cnt <= r_byte_cnt + LEN_W'(1);
              r_stall    <= r_wr & ~i_wvalid;
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        S_GAP: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + DIV_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_spi_cs_n = r_cs_n;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_rvalid   = r_rvalid;
  assign o_rdata    = r_rdata;

endmodule

// File: tb/tb_spi_mem_burst_ctrl.sv
// Self-checking bench: behavioural SPI SRAM on the bus, vector table of bursts scored
// against a reference memory, plus reset, held-start and 2-byte-address sequences.
module tb_spi_mem_burst_ctrl;

  localparam int K = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n = 1'b0, start = 1'b0, wr = 1'b0, wvalid = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00, rdata;
  logic [1:0] len = 2'd0;
  logic       wready, rvalid, busy, done, cs_n, sck, mosi;
  logic       miso = 1'b0;

  spi_mem_burst_ctrl #(.ADDR_BYTES(1), .MAX_BURST(4), .CLK_DIV(K)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_wr(wr), .i_addr(addr), .i_len(len),
    .i_wdata(wdata), .i_wvalid(wvalid), .o_wready(wready), .o_rdata(rdata), .o_rvalid(rvalid),
    .o_busy(busy), .o_done(done), .o_spi_cs_n(cs_n), .o_spi_sck(sck), .o_spi_mosi(mosi),
    .i_spi_miso(miso)
  );

  logic        start2 = 1'b0, wr2 = 1'b0, wvalid2 = 1'b0, miso2 = 1'b1;
  logic [15:0] addr2 = 16'h0000;
  logic [1:0]  len2 = 2'd0;
  logic [7:0]  wdata2 = 8'h00, rdata2;
  logic        wready2, rvalid2, busy2, done2, cs2_n, sck2, mosi2;

  spi_mem_burst_ctrl #(.ADDR_BYTES(2), .MAX_BURST(4), .CLK_DIV(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_wr(wr2), .i_addr(addr2), .i_len(len2),
    .i_wdata(wdata2), .i_wvalid(wvalid2), .o_wready(wready2), .o_rdata(rdata2), .o_rvalid(rvalid2),
    .o_busy(busy2), .o_done(done2), .o_spi_cs_n(cs2_n), .o_spi_sck(sck2), .o_spi_mosi(mosi2),
    .i_spi_miso(miso2)
  );

  // Behavioural SPI SRAM: READ/WRITE with auto-increment, logs every MOSI byte per select
  logic [7:0] smem [256];
  logic [7:0] s_rx = 8'h00, s_tx = 8'h00, s_addr = 8'h00;
  int         s_bits = 0, s_bytes = 0, mosi_cnt = 0;
  logic       s_psck = 1'b0, s_pcs = 1'b1;
  logic [7:0] mosi_log [16];

  always @(negedge clk) begin
    if (!rst_n) begin
      smem[8'h12] = 8'hA5;
      smem[8'hFE] = 8'h3C;
    end
    if (cs_n) begin
      s_bits = 0; s_bytes = 0; miso = 1'b0;
    end else begin
      if (s_pcs) mosi_cnt = 0;
      if (!s_psck && sck) begin
        s_rx = {s_rx[6:0], mosi};
        s_bits++;
        if (s_bits == 8) begin
          s_bits = 0;
          if (mosi_cnt < 16) mosi_log[mosi_cnt] = s_rx;
          mosi_cnt++;
          if (s_bytes == 1) s_addr = s_rx;
          else if (s_bytes >= 2) begin
            if (mosi_log[0] == 8'h02) smem[s_addr] = s_rx;
            s_addr = s_addr + 8'd1;
          end
          s_bytes++;
          if (s_bytes >= 2) s_tx = smem[s_addr];
        end
      end
      if (!sck) miso = (mosi_log[0] == 8'h03 && s_bytes >= 2) ? s_tx[3'(7 - s_bits)] : 1'b0;
    end
    s_psck = sck;
    s_pcs  = cs_n;
  end

  logic [7:0] rx2 = 8'h00;
  int         bits2 = 0, mlog2_cnt = 0, rise2_cnt = 0;
  int         rise2_cyc [2];
  logic [7:0] mlog2 [8];
  logic       p_sck2 = 1'b0;

  always @(negedge clk) begin
    if (cs2_n) bits2 = 0;
    else if (!p_sck2 && sck2) begin
      if (rise2_cnt < 2) rise2_cyc[rise2_cnt] = cyc;
      rise2_cnt++;
      rx2 = {rx2[6:0], mosi2};
      bits2++;
      if (bits2 == 8) begin
        bits2 = 0;
        if (mlog2_cnt < 8) mlog2[mlog2_cnt] = rx2;
        mlog2_cnt++;
      end
    end
    p_sck2 = sck2;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [1:0]  len;
    logic [31:0] wd;
    int          stall_at;
    int          stall_len;
    int          exp_lat;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] ref_mem [256];
  logic [7:0] exp_rq [$];
  logic [7:0] exp_mq [$];
  logic [31:0] wbytes = 32'h0;
  int rv_cnt = 0, wr_cnt = 0, stall_cnt = 0, wr_idx = 0, stall_at = -1, stall_len = 0;

  // One cycle: score rvalid against the queue, drive the write stream, count handshakes
  task automatic tick();
    @(negedge clk);
    if (rvalid) begin
      rv_cnt++;
      if (exp_rq.size() > 0) check("rdata", {24'h0, rdata}, {24'h0, exp_rq.pop_front()});
      else begin
        n_cmp++; n_bad++;
        $display("FAIL rvalid: unexpected pulse with rdata %02h, required none", rdata);
      end
    end
    wvalid = !(wr_idx == stall_at && stall_cnt < stall_len);
    wdata  = (wr_idx < 4) ? wbytes[31 - 8*wr_idx -: 8] : 8'h00;
    if (wready && !wvalid && stall_cnt > 0) check("stall_sck_cs", {30'h0, sck, cs_n}, 32'h0);
    if (wready && wvalid) begin
      wr_idx++; wr_cnt++;
    end else if (wready) stall_cnt++;
  endtask

  task automatic run_txn(input vec_t v);
    int a, guard, gap;
    logic [7:0] b;
    wbytes = v.wd; wr_idx = 0; stall_cnt = 0; stall_at = v.stall_at; stall_len = v.stall_len;
    rv_cnt = 0; wr_cnt = 0;
    exp_mq.delete(); exp_rq.delete();
    exp_mq.push_back(v.wr ? 8'h02 : 8'h03);
    exp_mq.push_back(v.addr);
    for (int k = 0; k <= int'(v.len); k++) begin
      b = v.wd[31 - 8*k -: 8];
      if (v.wr) begin
        exp_mq.push_back(b);
        ref_mem[8'(v.addr + k)] = b;
      end else begin
        exp_mq.push_back(8'h00);
        exp_rq.push_back(ref_mem[8'(v.addr + k)]);
      end
    end
    start = 1'b1; wr = v.wr; addr = v.addr; len = v.len;
    a = cyc;
    tick();
    start = 1'b0;
    guard = 0;
    while (!done && guard < 2000) begin tick(); guard++; end
    check("done_seen", {31'h0, done}, 32'h1);
    check("latency", cyc - a, v.exp_lat);
    check("cs_n_on_done", {31'h0, cs_n}, 32'h1);
    gap = 0;
    while (busy && gap < 100) begin tick(); gap++; end
    check("busy_fall", gap, K);
    if (v.wr) check("wready_pulses", wr_cnt, int'(v.len) + 1);
    else      check("rvalid_pulses", rv_cnt, int'(v.len) + 1);
    check("mosi_count", mosi_cnt, exp_mq.size());
    for (int i = 0; i < mosi_cnt && i < 16; i++)
      if (exp_mq.size() > 0) check("mosi_byte", {24'h0, mosi_log[i]}, {24'h0, exp_mq.pop_front()});
    $display("txn wr=%0b addr=%02h len=%0d latency=%0d", v.wr, v.addr, v.len, cyc - a - gap);
  endtask

  initial begin
    int a, guard, d1, d2, csh, lows, dn, r2;
    vecs[0] = '{1'b0, 8'h12, 2'd0, 32'h0,        -1, 0,  99};
    vecs[1] = '{1'b1, 8'h40, 2'd3, 32'h11223344, -1, 0, 195};
    vecs[2] = '{1'b0, 8'h40, 2'd3, 32'h0,        -1, 0, 195};
    vecs[3] = '{1'b1, 8'h80, 2'd3, 32'hA1B2C3D4,  1, 10, 205};
    vecs[4] = '{1'b0, 8'h80, 2'd3, 32'h0,        -1, 0, 195};
    vecs[5] = '{1'b1, 8'hFF, 2'd0, 32'h5A000000, -1, 0,  99};
    vecs[6] = '{1'b0, 8'hFF, 2'd0, 32'h0,        -1, 0,  99};
    vecs[7] = '{1'b0, 8'hFE, 2'd1, 32'h0,        -1, 0, 131};
    ref_mem[8'h12] = 8'hA5;
    ref_mem[8'hFE] = 8'h3C;

    // Start presented while reset is asserted must be dropped
    rst_n = 1'b0; start = 1'b1; wr = 1'b0; addr = 8'h12;
    repeat (3) tick();
    start = 1'b0; rst_n = 1'b1;
    tick();
    check("rst_cs_n", {31'h0, cs_n}, 32'h1);
    check("rst_sck", {31'h0, sck}, 32'h0);
    check("rst_mosi", {31'h0, mosi}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_rvalid", {31'h0, rvalid}, 32'h0);
    check("rst_wready", {31'h0, wready}, 32'h0);
    check("rst_rdata", {24'h0, rdata}, 32'h0);

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset pulse during the address phase aborts without done
    start = 1'b1; wr = 1'b0; addr = 8'h12; len = 2'd0;
    a = cyc;
    tick();
    start = 1'b0;
    while (cyc < a + 40) tick();
    check("abort_busy_before", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_cs_n", {31'h0, cs_n}, 32'h1);
    check("abort_sck", {31'h0, sck}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    dn = 0;
    repeat (120) begin tick(); if (done) dn++; end
    check("abort_no_done", dn, 0);
    $display("txn aborted read addr=12 by reset");
    run_txn(vecs[0]);

    // Start held high: one transaction per IDLE entry, deselect gap between them
    exp_rq.delete(); rv_cnt = 0;
    exp_rq.push_back(8'hA5); exp_rq.push_back(8'hA5);
    start = 1'b1; wr = 1'b0; addr = 8'h12; len = 2'd0;
    a = cyc; d1 = -1; d2 = -1; csh = 0; guard = 0;
    while (d2 < 0 && guard < 400) begin
      tick(); guard++;
      if (done) begin
        if (d1 < 0) d1 = cyc;
        else begin d2 = cyc; start = 1'b0; end
      end
      if (d1 >= 0 && d2 < 0 && cs_n) csh++;
    end
    start = 1'b0;
    check("held_first_done", d1 - a, 99);
    check("held_second_done", d2 - d1, 101);
    check("held_cs_high_cycles", csh, K + 1);
    lows = 0;
    repeat (150) begin tick(); if (!cs_n) lows++; end
    check("held_no_third", lows, 0);
    check("held_rvalid_pulses", rv_cnt, 2);
    $display("txn held-start reads addr=12 done at +%0d and +%0d", d1 - a, d2 - a);

    // Two address bytes, one clk per SCK half-period
    start2 = 1'b1; wr2 = 1'b0; addr2 = 16'h0123; len2 = 2'd0;
    a = cyc; r2 = -1;
    tick();
    start2 = 1'b0;
    guard = 0;
    while (!done2 && guard < 500) begin
      tick(); guard++;
      if (rvalid2) r2 = int'(rdata2);
    end
    check("ab2_done_seen", {31'h0, done2}, 32'h1);
    check("ab2_latency", cyc - a, 66);
    check("ab2_mosi_count", mlog2_cnt, 4);
    check("ab2_op", {24'h0, mlog2[0]}, 32'h03);
    check("ab2_addr_hi", {24'h0, mlog2[1]}, 32'h01);
    check("ab2_addr_lo", {24'h0, mlog2[2]}, 32'h23);
    check("ab2_rdata", r2, 32'hFF);
    check("ab2_sck_period", rise2_cyc[1] - rise2_cyc[0], 2);
    $display("txn dut2 read addr=0123 latency=%0d", cyc - a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
